// File: rtl/scr1_tb_mem_pkg.sv
// Shared types and helpers for the multi-port AHB-Lite test memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scr1_tb_mem_pkg;

    typedef enum logic [1:0] {
        SCR1_TB_MEM_FSM_IDLE = 2'd0,
        SCR1_TB_MEM_FSM_DATA = 2'd1,
        SCR1_TB_MEM_FSM_ERR1 = 2'd2,
        SCR1_TB_MEM_FSM_ERR2 = 2'd3
    } type_scr1_tb_mem_fsm_e;

    localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] SCR1_HSIZE_8B  = 3'd0;
    localparam logic [2:0] SCR1_HSIZE_16B = 3'd1;
    localparam logic [2:0] SCR1_HSIZE_32B = 3'd2;

    // Unsupported sizes count as misaligned so they take the error path too
    function automatic logic scr1_tb_mem_misaligned(input logic [2:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            SCR1_HSIZE_8B:  bad = 1'b0;
            SCR1_HSIZE_16B: bad = lsb[0];
            SCR1_HSIZE_32B: bad = |lsb;
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by an aligned access of the given size
    function automatic logic [3:0] scr1_tb_mem_byte_en(input logic [2:0] size, input logic [1:0] lsb);
        logic [3:0] be;
        case (size)
            SCR1_HSIZE_8B:  be = 4'b0001 << lsb;
            SCR1_HSIZE_16B: be = lsb[1] ? 4'b1100 : 4'b0011;
            default:        be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/scr1_tb_ahb_mem_port.sv
// One AHB-Lite slave port: address latch, wait-state pattern and response FSM.
// Latency: data phase completes one cycle after the address phase plus one cycle per 0 in the pattern.
// Backpressure: hready_o low while the pattern stalls and during the first error cycle.
module scr1_tb_ahb_mem_port
    import scr1_tb_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] stall_pattern_i,
    input  logic [1:0]  htrans_i,
    input  logic [31:0] haddr_i,
    input  logic [2:0]  hsize_i,
    input  logic        hwrite_i,
    output logic        hready_o,
    output logic        hresp_o,
    output logic        rd_cmpl_o,
    output logic        wr_cmpl_o,
    output logic [31:0] addr_o,
    output logic [2:0]  size_o
);

    type_scr1_tb_mem_fsm_e state_q;
    logic [31:0]           pat_q;
    logic [31:0]           addr_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic                  addr_ph;
    logic                  data_done;

    assign data_done = (state_q == SCR1_TB_MEM_FSM_DATA) & pat_q[0];
    assign hready_o  = (state_q == SCR1_TB_MEM_FSM_DATA) ? pat_q[0]
                                                        : (state_q != SCR1_TB_MEM_FSM_ERR1);
    assign hresp_o   = (state_q == SCR1_TB_MEM_FSM_ERR1) | (state_q == SCR1_TB_MEM_FSM_ERR2);
    assign addr_ph   = ((htrans_i == SCR1_HTRANS_NONSEQ) | (htrans_i == SCR1_HTRANS_SEQ)) & hready_o;

    assign rd_cmpl_o = data_done & ~write_q;
    assign wr_cmpl_o = data_done &  write_q;
    assign addr_o    = addr_q;
    assign size_o    = size_q;

    // Response FSM; an all-zero pattern would never complete, so it is loaded as all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCR1_TB_MEM_FSM_IDLE;
            pat_q   <= (stall_pattern_i == '0) ? '1 : stall_pattern_i;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            if (state_q == SCR1_TB_MEM_FSM_DATA) begin
                pat_q <= {pat_q[0], pat_q[31:1]};
            end
            if (addr_ph) begin
                state_q <= scr1_tb_mem_misaligned(hsize_i, haddr_i[1:0]) ? SCR1_TB_MEM_FSM_ERR1
                                                                         : SCR1_TB_MEM_FSM_DATA;
                addr_q  <= haddr_i;
                size_q  <= hsize_i;
                write_q <= hwrite_i;
            end else if (state_q == SCR1_TB_MEM_FSM_ERR1) begin
                state_q <= SCR1_TB_MEM_FSM_ERR2;
            end else if ((state_q != SCR1_TB_MEM_FSM_DATA) || pat_q[0]) begin
                state_q <= SCR1_TB_MEM_FSM_IDLE;
            end
        end
    end

endmodule

// File: rtl/scr1_tb_ahb_mem_mp.sv
// Multi-port AHB-Lite memory model over one shared byte array; optional exit register (SCR1_TB_MEM_EXIT_REG_EN).
// Latency: per-port, set by that port's wait-state pattern; reads see data before same-edge writes.
// Backpressure: each port stalls independently; same-byte write collisions resolve to the lowest port.
module scr1_tb_ahb_mem_mp
    import scr1_tb_mem_pkg::*;
#(
    parameter int          PORT_NUM       = 2,
    parameter int          MEM_POWER_SIZE = 24,
    parameter logic [31:0] EXIT_REG_ADDR  = 32'hF000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORT_NUM-1:0][31:0] stall_pattern_in,
    input  logic [PORT_NUM-1:0][1:0]  htrans,
    input  logic [PORT_NUM-1:0][31:0] haddr,
    input  logic [PORT_NUM-1:0][2:0]  hsize,
    input  logic [PORT_NUM-1:0]       hwrite,
    input  logic [PORT_NUM-1:0][31:0] hwdata,
    output logic [PORT_NUM-1:0]       hready,
    output logic [PORT_NUM-1:0][31:0] hrdata,
    output logic [PORT_NUM-1:0]       hresp,
    output logic                     test_done,
    output logic [31:0]              test_code
);

    localparam int MEM_SIZE = 1 << MEM_POWER_SIZE;

    logic [7:0] memory [0:MEM_SIZE-1];

    logic [PORT_NUM-1:0]                     rd_cmpl;
    logic [PORT_NUM-1:0]                     wr_cmpl;
    logic [PORT_NUM-1:0][31:0]               addr_w;
    logic [PORT_NUM-1:0][2:0]                size_w;
    logic [PORT_NUM-1:0][MEM_POWER_SIZE-3:0] word_idx;
    logic [PORT_NUM-1:0][3:0]                be_w;
    logic [PORT_NUM-1:0]                     exit_hit;
    logic [PORT_NUM-1:0][31:0]               rd_word;
    logic [PORT_NUM-1:0][31:0]               hrdata_q;

    genvar gp;
    generate
        for (gp = 0; gp < PORT_NUM; gp++) begin : g_port
            scr1_tb_ahb_mem_port i_port (
                .clk             (clk),
                .rst_n           (rst_n),
                .stall_pattern_i (stall_pattern_in[gp]),
                .htrans_i        (htrans[gp]),
                .haddr_i         (haddr[gp]),
                .hsize_i         (hsize[gp]),
                .hwrite_i        (hwrite[gp]),
                .hready_o        (hready[gp]),
                .hresp_o         (hresp[gp]),
                .rd_cmpl_o       (rd_cmpl[gp]),
                .wr_cmpl_o       (wr_cmpl[gp]),
                .addr_o          (addr_w[gp]),
                .size_o          (size_w[gp])
            );
        end
    endgenerate

    // Per-port word index (address wraps at the array size), lane mask and read word
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            word_idx[p] = addr_w[p][MEM_POWER_SIZE-1:2];
            be_w[p]     = scr1_tb_mem_byte_en(size_w[p], addr_w[p][1:0]);
`ifdef SCR1_TB_MEM_EXIT_REG_EN
            exit_hit[p] = ({addr_w[p][31:2], 2'b00} == EXIT_REG_ADDR);
`else
            exit_hit[p] = 1'b0;
`endif
            rd_word[p]  = {memory[{word_idx[p], 2'd3}], memory[{word_idx[p], 2'd2}],
                           memory[{word_idx[p], 2'd1}], memory[{word_idx[p], 2'd0}]};
            if (exit_hit[p]) begin
                rd_word[p] = test_code;
            end
        end
    end

    // Read data is live in the completing cycle and held from the register otherwise
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            hrdata[p] = rd_cmpl[p] ? rd_word[p] : hrdata_q[p];
        end
    end

    // Capture the last completed read word per port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hrdata_q <= '0;
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                if (rd_cmpl[p]) begin
                    hrdata_q[p] <= rd_word[p];
                end
            end
        end
    end

    // Byte-lane writes; descending loop so the lowest port's NBA lands last and wins
    always_ff @(posedge clk) begin
        for (int p = PORT_NUM - 1; p >= 0; p--) begin
            if (wr_cmpl[p] && !exit_hit[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_w[p][b]) begin
                        memory[{word_idx[p], b[1:0]}] <= hwdata[p][8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef SCR1_TB_MEM_EXIT_REG_EN
    // Sticky test-exit flag and code, lowest port wins on collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            test_done <= 1'b0;
            test_code <= '0;
        end else begin
            for (int p = PORT_NUM - 1; p >= 0; p--) begin
                if (wr_cmpl[p] && exit_hit[p] && (size_w[p] == SCR1_HSIZE_32B)) begin
                    test_done <= 1'b1;
                    test_code <= hwdata[p];
                end
            end
        end
    end
`else
    logic unused_bits;

    assign test_done   = 1'b0;
    assign test_code   = '0;
    assign unused_bits = ^{addr_w, EXIT_REG_ADDR};
`endif

endmodule

// File: tb/tb_scr1_tb_ahb_mem_mp.sv
// Directed bench for the multi-port AHB-Lite memory model.
// Drives inputs 1ns after posedge and samples 5ns after posedge.
// Every transfer wait is bounded by a cycle budget.
module tb_scr1_tb_ahb_mem_mp;
    import scr1_tb_mem_pkg::*;

`ifdef SCR1_TB_MEM_EXIT_REG_EN
    localparam logic EXIT_EN = 1'b1;
`else
    localparam logic EXIT_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [1:0][31:0]  stall_pattern_in;
    logic [1:0][1:0]   htrans;
    logic [1:0][31:0]  haddr;
    logic [1:0][2:0]   hsize;
    logic [1:0]        hwrite;
    logic [1:0][31:0]  hwdata;
    logic [1:0]        hready;
    logic [1:0][31:0]  hrdata;
    logic [1:0]        hresp;
    logic              test_done;
    logic [31:0]       test_code;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rd;
    int          wt;
    int          er;

    scr1_tb_ahb_mem_mp #(
        .PORT_NUM       (2),
        .MEM_POWER_SIZE (16),
        .EXIT_REG_ADDR  (32'hF000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_pattern_in (stall_pattern_in),
        .htrans           (htrans),
        .haddr            (haddr),
        .hsize            (hsize),
        .hwrite           (hwrite),
        .hwdata           (hwdata),
        .hready           (hready),
        .hrdata           (hrdata),
        .hresp            (hresp),
        .test_done        (test_done),
        .test_code        (test_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Single transfer on one port; starts and ends 1ns after a posedge
    task automatic xfer(input int p, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int waits,
                        output int errs);
        int  n;
        bit  done;
        waits = 0;
        errs  = 0;
        rdata = '0;
        htrans[p] = SCR1_HTRANS_NONSEQ;
        haddr[p]  = addr;
        hsize[p]  = size;
        hwrite[p] = wr;
        @(posedge clk); #1;
        htrans[p] = SCR1_HTRANS_IDLE;
        hwdata[p] = wdata;
        n    = 0;
        done = 0;
        while (!done) begin
            #4;
            if (hresp[p]) errs++;
            if (hready[p]) begin
                rdata = hrdata[p];
                done  = 1;
            end else begin
                waits++;
                n++;
                if (n > 40) begin
                    check_eq("xfer_timeout", 32'(n), 32'd40);
                    done = 1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic [31:0] p0, input logic [31:0] p1);
        rst_n               = 1'b0;
        stall_pattern_in[0] = p0;
        stall_pattern_in[1] = p1;
        htrans              = '0;
        haddr               = '0;
        hsize               = '0;
        hwrite              = '0;
        hwdata              = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        #4;
        check_eq({tag, "_hready"}, 32'(hready), 32'h3);
        check_eq({tag, "_hresp"}, 32'(hresp), 32'h0);
        check_eq({tag, "_hrdata0"}, hrdata[0], 32'h0);
        check_eq({tag, "_hrdata1"}, hrdata[1], 32'h0);
        check_eq({tag, "_test_done"}, 32'(test_done), 32'h0);
        check_eq({tag, "_test_code"}, test_code, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Phase A: port 0 pattern 0 (treated as ones), port 1 ones
        do_reset(32'h0, 32'hFFFF_FFFF);
        check_reset_state("rstA");

        // Zero-wait word write and read back
        xfer(0, 1'b1, 32'h100, SCR1_HSIZE_32B, 32'hDEAD_BEEF, rd, wt, er);
        check_eq("t1_wr_waits", 32'(wt), 32'd0);
        xfer(0, 1'b0, 32'h100, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("t1_rd_waits", 32'(wt), 32'd0);
        check_eq("t1_rd_data", rd, 32'hDEAD_BEEF);

        // BUSY gets a zero-wait OKAY and never touches memory
        htrans[0] = SCR1_HTRANS_BUSY;
        haddr[0]  = 32'h100;
        hsize[0]  = SCR1_HSIZE_32B;
        hwrite[0] = 1'b1;
        #4;
        check_eq("busy_hready", 32'(hready[0]), 32'd1);
        check_eq("busy_hresp", 32'(hresp[0]), 32'd0);
        @(posedge clk); #1;
        htrans[0] = SCR1_HTRANS_IDLE;
        hwdata[0] = 32'hFFFF_FFFF;
        #4;
        check_eq("busy_next_hready", 32'(hready[0]), 32'd1);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h100, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("busy_mem_kept", rd, 32'hDEAD_BEEF);

        // Lane masking and misalignment errors
        xfer(0, 1'b1, 32'h104, SCR1_HSIZE_32B, 32'h1122_3344, rd, wt, er);
        xfer(0, 1'b1, 32'h106, SCR1_HSIZE_8B, 32'h55AA_6677, rd, wt, er);
        xfer(0, 1'b0, 32'h104, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("t3_byte_wr", rd, 32'h11AA_3344);
        xfer(0, 1'b1, 32'h105, SCR1_HSIZE_16B, 32'hFFFF_FFFF, rd, wt, er);
        check_eq("t3_half_mis_errs", 32'(er), 32'd2);
        check_eq("t3_half_mis_waits", 32'(wt), 32'd1);
        xfer(0, 1'b0, 32'h104, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("t3_mis_unchanged", rd, 32'h11AA_3344);
        check_eq("t3_ok_errs", 32'(er), 32'd0);
        xfer(1, 1'b0, 32'h104, 3'd3, 32'h0, rd, wt, er);
        check_eq("t3_size3_errs", 32'(er), 32'd2);
        xfer(0, 1'b1, 32'h106, SCR1_HSIZE_16B, 32'hBEEF_1234, rd, wt, er);
        xfer(1, 1'b0, 32'h104, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("t3_half_wr", rd, 32'hBEEF_3344);

        // Both ports write the same word on the same edge
        for (int p = 0; p < 2; p++) begin
            htrans[p] = SCR1_HTRANS_NONSEQ;
            haddr[p]  = 32'h200;
            hsize[p]  = SCR1_HSIZE_32B;
            hwrite[p] = 1'b1;
        end
        @(posedge clk); #1;
        htrans    = '0;
        hwdata[0] = 32'h1;
        hwdata[1] = 32'h2;
        #4;
        check_eq("t4_dual_hready", 32'(hready), 32'h3);
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h200, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("t4_low_port_wins", rd, 32'h1);

        // Read on port 1 completing on the same edge as a port 0 write sees old data
        htrans[0] = SCR1_HTRANS_NONSEQ; haddr[0] = 32'h200; hsize[0] = SCR1_HSIZE_32B; hwrite[0] = 1'b1;
        htrans[1] = SCR1_HTRANS_NONSEQ; haddr[1] = 32'h200; hsize[1] = SCR1_HSIZE_32B; hwrite[1] = 1'b0;
        @(posedge clk); #1;
        htrans    = '0;
        hwdata[0] = 32'h3;
        #4;
        check_eq("t4_rd_old", hrdata[1], 32'h1);
        @(posedge clk); #1;
        #4;
        check_eq("t4_rd_hold", hrdata[1], 32'h1);
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h200, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("t4_rd_new", rd, 32'h3);

        // Back-to-back: read address phase overlaps the write data phase
        htrans[0] = SCR1_HTRANS_NONSEQ; haddr[0] = 32'h400; hsize[0] = SCR1_HSIZE_32B; hwrite[0] = 1'b1;
        @(posedge clk); #1;
        hwrite[0] = 1'b0;
        hwdata[0] = 32'h5A5A_1234;
        #4;
        check_eq("b2b_wr_hready", 32'(hready[0]), 32'd1);
        @(posedge clk); #1;
        htrans[0] = SCR1_HTRANS_IDLE;
        #4;
        check_eq("b2b_rd_hready", 32'(hready[0]), 32'd1);
        check_eq("b2b_rd_data", hrdata[0], 32'h5A5A_1234);
        @(posedge clk); #1;

        // Value for the reset-abort check
        xfer(0, 1'b1, 32'h300, SCR1_HSIZE_32B, 32'hCAFE_F00D, rd, wt, er);

        // Exit register (memory-mapped when the option is off)
        xfer(0, 1'b1, 32'hF000_0000, SCR1_HSIZE_32B, 32'h0BAD_C0DE, rd, wt, er);
        check_eq("exit_done", 32'(test_done), 32'(EXIT_EN));
        check_eq("exit_code", test_code, EXIT_EN ? 32'h0BAD_C0DE : 32'h0);
        xfer(1, 1'b0, 32'hF000_0000, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("exit_rd", rd, 32'h0BAD_C0DE);

        // ---------------- Phase B: port 0 long stall, port 1 pattern 0x5
        do_reset(32'h8000_0000, 32'h0000_0005);
        check_reset_state("rstB");

        xfer(1, 1'b0, 32'h100, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("t2_rd1_waits", 32'(wt), 32'd0);
        check_eq("t2_rd1_data", rd, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 32'h100, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("t2_rd2_waits", 32'(wt), 32'd1);
        check_eq("t2_rd2_data", rd, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 32'h100, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("t2_rd3_waits", 32'(wt), 32'd29);
        check_eq("t2_rd3_data", rd, 32'hDEAD_BEEF);

        // Reset during a stalled write drops it
        stall_pattern_in[0] = 32'hFFFF_FFFF;
        htrans[0] = SCR1_HTRANS_NONSEQ; haddr[0] = 32'h300; hsize[0] = SCR1_HSIZE_32B; hwrite[0] = 1'b1;
        @(posedge clk); #1;
        htrans[0] = SCR1_HTRANS_IDLE;
        hwdata[0] = 32'h1234_5678;
        #4;
        check_eq("rstw_stall1", 32'(hready[0]), 32'd0);
        @(posedge clk); #1;
        #4;
        check_eq("rstw_stall2", 32'(hready[0]), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rstw_hready", 32'(hready[0]), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(0, 1'b0, 32'h300, SCR1_HSIZE_32B, 32'h0, rd, wt, er);
        check_eq("rstw_waits", 32'(wt), 32'd0);
        check_eq("rstw_unchanged", rd, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scr1_tb_ahb_mem_mp.md
# scr1_tb_ahb_mem_mp

Parametrised multi-port AHB-Lite slave memory model for the AHB simulation top. It serves PORT_NUM independent AHB-Lite masters (core imem, core dmem, debug/DMA agents) from one shared byte array. Each port has its own programmable wait-state pattern, error response on misalignment, and byte-lane write masking. An optional test-exit register lets software end a test by writing a result code, instead of the bench polling the PC.

## Interface
- PORT_NUM, 2: number of AHB-Lite slave ports (1..8)
- MEM_POWER_SIZE, 24: memory size is 2^MEM_POWER_SIZE bytes; addresses wrap modulo this size
- EXIT_REG_ADDR, 32'hF000_0000: byte address of the exit register (only with SCR1_TB_MEM_EXIT_REG_EN)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall_pattern_in  in  [PORT_NUM][32]  per-port wait-state pattern, loaded while rst_n=0
- htrans  in  [PORT_NUM][2]  AHB transfer type
- haddr  in  [PORT_NUM][32]  address
- hsize  in  [PORT_NUM][3]  size: 0 byte, 1 half, 2 word; other values are an error
- hwrite  in  [PORT_NUM][1]  write strobe
- hwdata  in  [PORT_NUM][32]  write data, data phase
- hready  out  [PORT_NUM][1]  transfer done / slave ready
- hrdata  out  [PORT_NUM][32]  read data
- hresp  out  [PORT_NUM][1]  0 OKAY, 1 ERROR
- test_done  out  1  exit register written (option only)
- test_code  out  32  value written to exit register (option only)

## Operation
- Per-port FSM with states IDLE, DATA, ERR1, ERR2.
- **Address phase:** accepted when htrans is NONSEQ or SEQ and hready=1. The FSM latches addr, size and write, then enters DATA. If the access is misaligned (half with addr[0]=1, word with addr[1:0]≠0) or hsize>2, it enters ERR1 instead.
- **DATA:** hready = pat[0]. When pat[0]=1 the transfer completes:
  - Read: hrdata carries the little-endian word at {addr[31:2],2'b00}, all 4 bytes, with no lane masking.
  - Write: the bytes selected by size/addr[1:0] are taken from the matching hwdata lanes and written at the completing clock edge.
  - On completion, a new address phase in the same cycle is accepted (back-to-back). Otherwise the FSM goes to IDLE.
- **ERR1:** hready=0, hresp=1. **ERR2:** hready=1, hresp=1. A new address phase during ERR2 is accepted.
- **Stall pattern:**
  - pat is a 32-bit register, loaded from stall_pattern_in during reset.
  - pat rotates right by 1 each cycle the FSM is in DATA.
  - An all-zero pattern is replaced by all-ones to avoid deadlock.
- **Conflicts:**
  - Two ports writing the same byte on the same edge: the lowest port index wins.
  - A read completing on the same edge as another port's write returns the old data.
- IDLE/BUSY htrans: zero-wait OKAY response, no memory access.
- Memory contents are not cleared by reset. The bench preloads them via hierarchical $readmemh.

## Timing
- Reset values:
  - hready=1, hresp=0, hrdata=0.
  - FSM in IDLE.
  - test_done=0, test_code=0.
- Latency: address phase in cycle N. With pat[0]=1 at N+1, data completes in N+1. Each 0 bit adds one wait cycle.
- hrdata holds its last value outside completing read cycles.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately and the pending write is dropped.
- Error response is always exactly 2 cycles, independent of the stall pattern.

## Configuration
- SCR1_TB_MEM_EXIT_REG_EN defined:
  - A completed word write to EXIT_REG_ADDR sets test_done=1 (sticky until reset) and test_code=hwdata.
  - This address is not stored in memory. Reads of it return test_code.
- SCR1_TB_MEM_EXIT_REG_EN undefined:
  - No exit register; that address maps to memory like any other.
  - test_done and test_code are tied to 0.

## Structure
- Package scr1_tb_mem_pkg holds:
  - FSM state enum type_scr1_tb_mem_fsm_e.
  - HTRANS/HSIZE localparams.
  - Misalignment check function.
  - Byte-enable function (size, addr[1:0] → 4-bit mask).
- Sub-module scr1_tb_ahb_mem_port holds the per-port FSM, stall pattern and address latch. It is instantiated PORT_NUM times via generate.
- The top owns the shared array and write arbitration.

## Test plan
- Port 0 word write 0xDEADBEEF to 0x100 with pattern all-ones, then read -> hready never low; read returns 0xDEADBEEF one cycle after its address phase.
- Pattern 32'h0000_0005 on port 1, read 0x100 -> hready sequence during data phases 1,0,1,0,0..., i.e. one wait state on the second access.
- Byte write 0xAA at 0x102 over word 0x11223344 -> read returns 0x11AA3344; half write at 0x101 -> ERR1/ERR2 with hresp=1 for 2 cycles and memory unchanged.
- Ports 0 and 1 write 0x1 and 0x2 to 0x200 on the same edge -> read returns 0x00000001.
- With SCR1_TB_MEM_EXIT_REG_EN: write 0x0 to 0xF000_0000 -> test_done=1 next cycle, test_code=0; assert rst_n -> both return to 0.
- rst_n pulled low during a stalled write to 0x300 -> hready=1 immediately, 0x300 unchanged, and the next transfer after reset completes normally.
